// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
//   Bit-serial subtractor controller: diff = (a - b) mod 2^WIDTH, processed
//   LSB-first through two cascaded half subtractors and one borrow flop.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, sampled only while idle
//   a, b    in   minuend / subtrahend, captured on the accepting edge
//   busy    out  high while bits are being processed
//   done    out  one-cycle pulse, diff/borrow valid from this cycle
//   diff    out  registered result, held until the next completion
//   borrow  out  registered final borrow (1 iff a < b unsigned)
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] sa_q,     sa_d;
    logic [WIDTH-1:0] sb_q,     sb_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             bin_q,    bin_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    // One-bit datapath: two half subtractors on the current LSBs
    logic d1, b1, d_bit, b2;

    assign d1    = sa_q[0] ^ sb_q[0];
    assign b1    = ~sa_q[0] & sb_q[0];
    assign d_bit = d1 ^ bin_q;
    assign b2    = ~d1 & bin_q;

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                res_d = {d_bit, res_q[WIDTH-1:1]};
                bin_d = b1 | b2;
                cnt_d = cnt_q + 1'b1;
                busy_d = 1'b1;
                // Last bit: publish the fully shifted result straight from
                // this cycle's next-state so diff/borrow land on entry to DONE.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    diff_d   = res_d;
                    borrow_d = b1 | b2;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial multi-bit subtractor controller. It reuses one half-subtractor pair plus a borrow flip-flop, sequencing operands LSB-first over WIDTH cycles. It computes diff = a − b (mod 2^WIDTH) and a final borrow, with a start/busy/done handshake. It sits between a requesting master and the 1-bit subtractor datapath, trading area for latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend; captured on the accepting edge
- b  in  WIDTH  subtrahend; captured on the accepting edge
- busy  out  1  high while bits are being processed (SHIFT state)
- done  out  1  one-cycle pulse; diff/borrow valid from this cycle
- diff  out  WIDTH  registered result (a − b) mod 2^WIDTH
- borrow  out  1  registered final borrow-out; 1 iff a < b unsigned

## Operation
- States: IDLE, SHIFT, DONE; encoding is free.
- IDLE:
  - start=1 loads a into sa and b into sb, clears bin (borrow FF) and the bit counter, then goes to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, each cycle:
  - Stage 1 half subtractor: d1 = sa[0]^sb[0], b1 = ~sa[0]&sb[0].
  - Stage 2 half subtractor: d = d1^bin, b2 = ~d1&bin.
  - bin <= b1|b2.
  - d shifts into the MSB of the result shift register; sa and sb shift right by 1.
  - Counter increments.
  - After the WIDTH-th bit, go to DONE.
- DONE (one cycle):
  - diff <= result shift register; borrow <= final bin. Both update on the edge entering DONE.
  - done=1; next state is IDLE unconditionally.
- diff/borrow hold their last value until the next operation completes. They are not cleared by a new start.
- start in SHIFT or DONE is ignored and not queued. a/b changes after acceptance have no effect.
- Counter width is clog2(WIDTH)+1 bits. No arithmetic wider than 1 bit in the datapath.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0.
  - sa, sb, bin, counter and result shift register all cleared.
  - The aborted operation produces no done.
  - Release is synchronous to the next edge; first start is accepted on the first edge with rst_n=1.

## Timing
- E0 = rising edge that samples start=1 in IDLE.
- busy=1 from after E0 until after E_WIDTH: exactly WIDTH cycles.
- Bit i (LSB i=0) is processed on edge E(i+1).
- E_WIDTH: last bit processed; state → DONE, diff/borrow updated.
- done=1 from after E_WIDTH until after E(WIDTH+1); it is sampled high at E(WIDTH+1).
- Latency start→done = WIDTH+1 edges. Minimum issue interval = WIDTH+2 cycles (start held high gives back-to-back ops).
- busy and done are never high together; both are 0 in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: rst_n=0 with start=1, a=0xFF, b=0x01 → busy=0, done=0, diff=0x00, borrow=0 throughout reset.
- Basic (WIDTH=8): a=0x5A, b=0x23, one-cycle start →
  - busy high for 8 cycles;
  - done sampled high exactly at E9, for one cycle;
  - diff=0x37, borrow=0, held afterwards.
- Underflow and wrap:
  - a=0x00, b=0x01 → diff=0xFF, borrow=1.
  - Then a=0xFF, b=0xFF → diff=0x00, borrow=0; borrow updates from 1 to 0 at DONE.
- Ignored start: accept a=0x10, b=0x01, then pulse start at E3 with a=0x00, b=0xFF → single done at E9, diff=0x0F, borrow=0, no second op.
- Reset mid-op: accept a=0x80, b=0x01, drop rst_n at cycle 4 → outputs zero, no done. After release, a=0x09, b=0x03 → done at E9, diff=0x06.
- Back-to-back: start held high for two ops (0x03−0x05, then 0xC8−0x64) → done pulses 10 cycles apart; results 0xFE/borrow 1, then 0x64/borrow 0.
